run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 122 ++++++++++++
 tb/tb_run_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// run_controller: sequences processor reset, start pulse and run-to-completion.
// Define RUN_CTRL_TIMEOUT_EN to add a cycle-limit abort (TIMEOUT) to RUN.
module run_controller #(
  parameter int core_count = 4,
  parameter int rst_cycles = 4,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [core_count-1:0] endop_signal,
  input  logic [cnt_width-1:0]  timeout_limit,
  output logic                  sys_reset,
  output logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [core_count-1:0] done_mask,
  output logic [cnt_width-1:0]  cycle_count
);

  localparam int RC = (rst_cycles < 1) ? 1 : rst_cycles;
  localparam int RW = $clog2(RC + 1);
  localparam logic [RW-1:0] RC_LD = RW'(RC);

  typedef enum logic [2:0] {
    IDLE,
    RST,
    START,
    RUN,
    DONE,
    TIMEOUT
  } state_t;

  state_t state, state_nxt;

  logic [RW-1:0]         rcnt, rcnt_nxt;
  logic                  por;
  logic [core_count-1:0] mask_nxt;
  logic [core_count-1:0] hit;
  logic [cnt_width-1:0]  cnt_nxt;
  logic [cnt_width-1:0]  cnt_inc;
  logic                  all_done;
  logic                  limit_hit;

  // same-edge endops count toward completion
  assign hit      = done_mask | endop_signal;
  assign all_done = &hit;
  assign cnt_inc  = (&cycle_count) ? cycle_count
                  : cycle_count + cnt_width'(1);

`ifdef RUN_CTRL_TIMEOUT_EN
  assign limit_hit = (timeout_limit != '0) &&
                     (cnt_inc == timeout_limit);
`else
  logic unused_limit;
  assign unused_limit = ^timeout_limit;
  assign limit_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    mask_nxt  = done_mask;
    cnt_nxt   = cycle_count;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_nxt = RST;
          rcnt_nxt  = RC_LD;
          mask_nxt  = '0;
          cnt_nxt   = '0;
        end
      end
      RST: begin
        rcnt_nxt = rcnt - RW'(1);
        if (rcnt == RW'(1)) state_nxt = START;
      end
      START: state_nxt = RUN;
      RUN: begin
        mask_nxt = hit;
        cnt_nxt  = cnt_inc;
        if (all_done)       state_nxt = DONE;
        else if (limit_hit) state_nxt = TIMEOUT;
      end
      DONE, TIMEOUT: begin
        if (!go) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rcnt        <= '0;
      por         <= 1'b1;
      done_mask   <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      rcnt        <= rcnt_nxt;
      por         <= 1'b0;
      done_mask   <= mask_nxt;
      cycle_count <= cnt_nxt;
    end
  end

  // por keeps the system in reset until the first edge after release
  assign sys_reset = por || (state == RST);
  assign start     = (state == START);
  assign busy      = (state == RST) || (state == START) ||
                     (state == RUN);
  assign done      = (state == DONE);

`ifdef RUN_CTRL_TIMEOUT_EN
  assign timeout = (state == TIMEOUT);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed scenarios for run_controller, checked each
// cycle against an elapsed-time model plus hand-computed expectations.
module tb_run_controller;

  localparam int CC  = 4;
  localparam int RCE = 4;
  localparam int CW  = 16;

  logic          clk;
  logic          reset;
  logic          go;
  logic [CC-1:0] endop;
  logic [CW-1:0] limit;
  logic          sys_reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CC-1:0] done_mask;
  logic [CW-1:0] cycle_count;

  int n_chk  = 0;
  int n_fail = 0;
  int n_rst;

  run_controller #(
    .core_count(CC),
    .rst_cycles(RCE),
    .cnt_width (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .endop_signal (endop),
    .timeout_limit(limit),
    .sys_reset    (sys_reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .done_mask    (done_mask),
    .cycle_count  (cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // model: progress measured in cycles since go acceptance
  bit            m_por;
  bit            m_act;
  int            m_age;
  int            m_fin;
  logic [CC-1:0] m_mask;
  logic [CW-1:0] m_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_por  = 1'b1;
      m_act  = 1'b0;
      m_age  = 0;
      m_fin  = 0;
      m_mask = '0;
      m_cnt  = '0;
    end else begin
      m_por = 1'b0;
      if (m_fin != 0) begin
        if (!go) m_fin = 0;
      end else if (m_act) begin
        if (m_age > RCE + 1) begin
          m_mask = m_mask | endop;
          if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
          if (&m_mask) begin
            m_fin = 1;
            m_act = 1'b0;
          end
`ifdef RUN_CTRL_TIMEOUT_EN
          else if (limit != 0 && m_cnt == limit) begin
            m_fin = 2;
            m_act = 1'b0;
          end
`endif
        end
        m_age++;
      end else if (go) begin
        m_act  = 1'b1;
        m_age  = 1;
        m_mask = '0;
        m_cnt  = '0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_sys_reset", sys_reset,
        m_por || (m_act && m_age <= RCE));
    chk("m_start", start, m_act && m_age == RCE + 1);
    chk("m_busy", busy, m_act);
    chk("m_done", done, m_fin == 1);
    chk("m_timeout", timeout, m_fin == 2);
    chk("m_done_mask", done_mask, m_mask);
    chk("m_cycle_count", cycle_count, m_cnt);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // returns positioned in RUN cycle 1
  task automatic launch(input bit hold);
    go = 1'b1;
    cyc();
    if (!hold) go = 1'b0;
    repeat (RCE + 1) cyc();
  endtask

  logic [CC-1:0] tbl [1:12];

  initial begin
    go    = 1'b0;
    endop = '0;
    limit = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_sys_reset", sys_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mask", done_mask, 0);
    chk("rst_count", cycle_count, 0);
    #20 reset = 1'b1;
    #1;
    chk("rel_sys_reset_hold", sys_reset, 1);
    cyc();
    chk("first_edge_sys_reset", sys_reset, 0);

    // staggered completion
    foreach (tbl[k]) tbl[k] = '0;
    tbl[5]  = 4'b0001;
    tbl[7]  = 4'b0100;
    tbl[9]  = 4'b0010;
    tbl[12] = 4'b1000;
    go = 1'b1;
    cyc();
    go = 1'b0;
    n_rst = 0;
    while (sys_reset && n_rst < 20) begin
      n_rst++;
      cyc();
    end
    chk("rst_len", n_rst, RCE);
    chk("start_pulse", start, 1);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 1) chk("run_busy", busy, 1);
      if (k == 1) chk("run_start_low", start, 0);
      endop = tbl[k];
    end
    cyc();
    endop = '0;
    chk("stag_done", done, 1);
    chk("stag_mask", done_mask, 4'b1111);
    chk("stag_count", cycle_count, 12);
    cyc();
    chk("idle_done", done, 0);
    chk("idle_mask_hold", done_mask, 4'b1111);
    chk("idle_count_hold", cycle_count, 12);

    // simultaneous completion
    launch(1'b0);
    repeat (2) cyc();
    endop = 4'b1111;
    cyc();
    endop = '0;
    chk("simul_done", done, 1);
    chk("simul_mask", done_mask, 4'b1111);
    chk("simul_count", cycle_count, 3);
    cyc();

    // zero limit never aborts
    limit = '0;
    launch(1'b0);
    endop = 4'b0001;
    cyc();
    endop = '0;
    repeat (29) cyc();
    chk("lim0_busy", busy, 1);
    chk("lim0_timeout", timeout, 0);
    chk("lim0_count", cycle_count, 30);
    endop = 4'b1110;
    cyc();
    endop = '0;
    chk("lim0_done", done, 1);
    cyc();

`ifdef RUN_CTRL_TIMEOUT_EN
    limit = 20;
    launch(1'b0);
    endop = 4'b0001;
    cyc();
    endop = '0;
    for (int i = 0; i < 40 && !timeout; i++) cyc();
    chk("to_reached", timeout, 1);
    chk("to_mask", done_mask, 4'b0001);
    chk("to_count", cycle_count, 20);
    chk("to_busy", busy, 0);
    cyc();
    limit = 3;
    launch(1'b0);
    repeat (2) cyc();
    endop = 4'b1111;
    cyc();
    endop = '0;
    chk("prio_done", done, 1);
    chk("prio_timeout", timeout, 0);
    chk("prio_count", cycle_count, 3);
    cyc();
`else
    limit = 5;
    launch(1'b0);
    endop = 4'b0001;
    cyc();
    endop = '0;
    repeat (9) cyc();
    chk("tie_busy", busy, 1);
    chk("tie_timeout", timeout, 0);
    endop = 4'b1110;
    cyc();
    endop = '0;
    chk("tie_done", done, 1);
    chk("tie_count", cycle_count, 11);
    cyc();
`endif
    limit = '0;

    // reset mid-run at RUN cycle 6
    launch(1'b0);
    repeat (5) cyc();
    #2 reset = 1'b0;
    #1;
    chk("abort_sys_reset", sys_reset, 1);
    chk("abort_start", start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_timeout", timeout, 0);
    chk("abort_mask", done_mask, 0);
    chk("abort_count", cycle_count, 0);
    repeat (3) cyc();
    chk("abort_no_start", start, 0);
    reset = 1'b1;
    cyc();
    chk("abort_rel_sys_reset", sys_reset, 0);
    launch(1'b0);
    endop = 4'b1111;
    cyc();
    endop = '0;
    chk("rerun_done", done, 1);
    chk("rerun_count", cycle_count, 1);
    cyc();

    // endops during RST/START ignored; go held across DONE
    endop = 4'b1111;
    launch(1'b1);
    endop = '0;
    chk("ign_mask_run1", done_mask, 0);
    cyc();
    chk("ign_mask_run2", done_mask, 0);
    chk("ign_busy", busy, 1);
    endop = 4'b0011;
    cyc();
    endop = 4'b1100;
    cyc();
    endop = '0;
    chk("hold_done", done, 1);
    chk("hold_count", cycle_count, 3);
    repeat (5) cyc();
    chk("hold_still_done", done, 1);
    chk("hold_no_restart", busy, 0);
    go = 1'b0;
    cyc();
    chk("hold_idle", done, 0);
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk("hold_restart", busy, 1);
    repeat (RCE + 1) cyc();
    endop = 4'b1111;
    cyc();
    endop = '0;
    chk("hold_rerun_done", done, 1);
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
